pkt_queue_mc: RTL and testbench
===============================

# pkt_queue_mc

Synthesizable, parametrised multi-channel packet queue for the NoC testbench and endpoint logic. It replaces the single unbounded behavioural queue with NCH independent bounded circular FIFOs. Each FIFO has its own valid/ready push port. The FIFOs share one round-robin-arbitrated valid/ready output toward the router local input.

## Interface
Parameters:
- W, default 64: packet width in bits (pkt_t payload).
- DEPTH, default 8: entries per channel. Must be a power of two and at least 2.
- NCH, default 4: number of channels, at least 1. CW = max(1, $clog2(NCH)).

Ports:
- clk, in, 1: clock.
- arst_n, in, 1: reset, asynchronous, active-low; clock clk.
- in_valid, in, NCH: per-channel push request.
- in_pkt, in, NCH×W: per-channel push data.
- in_ready, out, NCH: per-channel push acceptance.
- out_valid, out, 1: a packet is presented.
- out_pkt, out, W: head packet of the granted channel.
- out_ch, out, CW: index of the granted channel.
- out_ready, in, 1: downstream accepts.
- occ, out, NCH×($clog2(DEPTH)+1): per-channel entry count.
- drop_cnt, out, NCH×16: per-channel dropped-packet count. Only meaningful with the configuration macro.

## Operation
- Storage per channel: a DEPTH×W array with write pointer wp, read pointer rp, and count.
  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - full = (count == DEPTH). empty = (count == 0).
- Push on channel c: in_valid[c] && in_ready[c] at a rising edge. This writes mem[c][wp], increments wp, and increments count.
- Pop: out_valid && out_ready at a rising edge. This increments rp[out_ch] and decrements count[out_ch].
- Simultaneous push and pop on the same channel leaves count unchanged and advances both pointers.
- occ[c] = count[c], driven directly from the register.
- Arbitration uses the round-robin pointer rr (CW bits).
  - The candidate is the first non-empty channel searching rr, rr+1, …, wrapping modulo NCH.
  - out_valid = any channel non-empty. out_pkt = mem[g][rp[g]]. out_ch = g.
  - On an accepted pop from channel g, rr <= (g+1) mod NCH.
- Grant lock (stability rule): the lock register is set when out_valid && !out_ready, and records g.
  - While the lock is set, g is the locked channel, and out_pkt and out_ch must not change.
  - The lock clears on handshake.
  - New pushes to other channels never alter a presented packet.
- Output mux read is combinational from the registers. Outputs never depend combinationally on in_valid or in_pkt.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert) sets:
  - all wp, rp, count, rr to 0 and lock to 0;
  - out_valid=0, out_ch=0, occ=0, drop_cnt=0;
  - in_ready all 1;
  - out_pkt to don't-care (0 preferred).
- Latency: a packet pushed at edge N shows out_valid=1 in the cycle after edge N. There is no same-cycle fall-through.
- Throughput: one pop per cycle in aggregate; one push per cycle per channel.
- in_ready[c] = !full[c], registered state only. A pop in the same cycle does not raise in_ready (no full-through).
- Full channel: in_ready[c]=0. in_valid is ignored and data is held upstream.
- Empty, all channels: out_valid=0 and out_ready is ignored.
- Reset mid-operation: contents are discarded immediately. Neither a pop nor a push completes on the reset edge.
- NCH=1: rr is constant 0 and out_ch=0.

## Configuration
- PKT_QUEUE_MC_DROP_EN undefined:
  - Backpressure mode as described above.
  - drop_cnt is tied to 0.
- PKT_QUEUE_MC_DROP_EN defined:
  - in_ready is constant all 1.
  - A push to a full channel is discarded: the FIFO is unchanged and drop_cnt[c] increments.
  - drop_cnt saturates at 16'hFFFF.
  - A push to a full channel coinciding with a pop from that channel is accepted, not dropped.

## Test plan
- Reset, then push 0xA1 on ch2 at edge 1 → out_valid=1, out_ch=2, out_pkt=0xA1 after edge 1; occ[2]=1; out_ready=1 at edge 2 → out_valid=0, occ[2]=0.
- Default build, DEPTH=8, out_ready=0: push 9 packets on ch0 → in_ready[0]=0 after the 8th push, 9th held; assert out_ready for 1 cycle → in_ready[0]=1 next cycle; FIFO order 0..7 preserved.
- Channels 0–3 each loaded with 2 packets, out_ready=1 → out_ch sequence 0,1,2,3,0,1,2,3 and 8 consecutive valid cycles.
- Lock: out_ready=0 with ch1 presenting 0x11, then push on ch0 → out_ch stays 1 and out_pkt stays 0x11 until the handshake.
- Drop build: fill ch3 (8 entries), push 3 more → drop_cnt[3]=3 and occ[3]=8. Full plus simultaneous pop and push → drop_cnt unchanged and the new packet lands at the tail.
- Assert arst_n=0 mid-burst with occ=5 → occ=0, out_valid=0 asynchronously; after release the first push is presented normally.

Source files
------------

// File: rtl/pkt_queue_mc.sv
// Multi-channel bounded packet queue: NCH circular FIFOs behind one round-robin output port.
// Define PKT_QUEUE_MC_DROP_EN to discard pushes into a full channel (and count them) instead of backpressuring.
module pkt_queue_mc #(
  parameter int unsigned W     = 64,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned NCH   = 4,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CNTW = AW + 1,
  localparam int unsigned CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic [NCH-1:0]        in_valid,
  input  logic [NCH*W-1:0]      in_pkt,
  output logic [NCH-1:0]        in_ready,
  output logic                  out_valid,
  output logic [W-1:0]          out_pkt,
  output logic [CW-1:0]         out_ch,
  input  logic                  out_ready,
  output logic [NCH*CNTW-1:0]   occ,
  output logic [NCH*16-1:0]     drop_cnt
);

  logic [W-1:0]    r_mem [NCH][DEPTH];
  logic [AW-1:0]   r_wp  [NCH];
  logic [AW-1:0]   r_rp  [NCH];
  logic [CNTW-1:0] r_cnt [NCH];
  logic [CW-1:0]   r_rr;
  logic            r_lock;
  logic [CW-1:0]   r_lock_ch;

  logic [NCH-1:0]  w_full;
  logic [NCH-1:0]  w_nonempty;
  logic [NCH-1:0]  w_push;
  logic [NCH-1:0]  w_pop_ch;
  logic [CW-1:0]   w_cand;
  logic [CW-1:0]   w_idx;
  logic [CW-1:0]   w_g;
  logic            w_pop;

  always_comb begin
    w_full     = '0;
    w_nonempty = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      w_full[c]     = (r_cnt[c] == CNTW'(DEPTH));
      w_nonempty[c] = (r_cnt[c] != '0);
    end
  end

  // Round-robin search: lowest offset from r_rr wins, so scan offsets from high to low.
  always_comb begin
    w_cand = '0;
    w_idx  = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      w_idx = CW'((int'(r_rr) + i) % int'(NCH));
      if (w_nonempty[w_idx]) w_cand = w_idx;
    end
  end

  // A presented-but-stalled packet keeps its channel until the handshake.
  assign w_g       = r_lock ? r_lock_ch : w_cand;
  assign out_valid = |w_nonempty;
  assign out_ch    = out_valid ? w_g : '0;
  assign out_pkt   = out_valid ? r_mem[w_g][r_rp[w_g]] : '0;
  assign w_pop     = out_valid && out_ready;

  always_comb begin
    w_pop_ch = '0;
    occ      = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      w_pop_ch[c]            = w_pop && (w_g == CW'(c));
      occ[c*CNTW +: CNTW]    = r_cnt[c];
    end
  end

`ifdef PKT_QUEUE_MC_DROP_EN
  logic [15:0]    r_drop [NCH];
  logic [NCH-1:0] w_drop;

  // A pop on the same edge frees the slot, so a full channel still accepts.
  assign in_ready = '1;
  assign w_push   = in_valid & (~w_full | w_pop_ch);
  assign w_drop   = in_valid & w_full & ~w_pop_ch;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int c = 0; c < int'(NCH); c++) r_drop[c] <= '0;
    end else begin
      for (int c = 0; c < int'(NCH); c++)
        if (w_drop[c] && (r_drop[c] != 16'hFFFF)) r_drop[c] <= r_drop[c] + 16'd1;
    end
  end

  always_comb begin
    drop_cnt = '0;
    for (int c = 0; c < int'(NCH); c++) drop_cnt[c*16 +: 16] = r_drop[c];
  end
`else
  assign in_ready = ~w_full;
  assign w_push   = in_valid & ~w_full;
  assign drop_cnt = '0;
`endif

  // Pointer, count, arbitration and lock state.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      for (int c = 0; c < int'(NCH); c++) begin
        r_wp[c]  <= '0;
        r_rp[c]  <= '0;
        r_cnt[c] <= '0;
      end
      r_rr      <= '0;
      r_lock    <= 1'b0;
      r_lock_ch <= '0;
    end else begin
      for (int c = 0; c < int'(NCH); c++) begin
        if (w_push[c])   r_wp[c] <= r_wp[c] + AW'(1);
        if (w_pop_ch[c]) r_rp[c] <= r_rp[c] + AW'(1);
        case ({w_push[c], w_pop_ch[c]})
          2'b10:   r_cnt[c] <= r_cnt[c] + CNTW'(1);
          2'b01:   r_cnt[c] <= r_cnt[c] - CNTW'(1);
          default: r_cnt[c] <= r_cnt[c];
        endcase
      end
      if (w_pop) begin
        r_rr   <= CW'((int'(w_g) + 1) % int'(NCH));
        r_lock <= 1'b0;
      end else if (out_valid) begin
        r_lock    <= 1'b1;
        r_lock_ch <= w_g;
      end
    end
  end

  // Payload storage needs no reset; count and pointers decide what is valid.
  always_ff @(posedge clk) begin
    for (int c = 0; c < int'(NCH); c++)
      if (w_push[c]) r_mem[c][r_wp[c]] <= in_pkt[c*W +: W];
  end

endmodule

// File: tb/tb_pkt_queue_mc.sv
// Directed testbench for pkt_queue_mc (W=64, DEPTH=8, NCH=4).
// Backpressure checks run in the default build; drop checks when PKT_QUEUE_MC_DROP_EN is defined.
module tb_pkt_queue_mc;

  logic         clk = 1'b0;
  logic         arst_n;
  logic [3:0]   in_valid;
  logic [255:0] in_pkt;
  logic [3:0]   in_ready;
  logic         out_valid;
  logic [63:0]  out_pkt;
  logic [1:0]   out_ch;
  logic         out_ready;
  logic [15:0]  occ;
  logic [63:0]  drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  pkt_queue_mc #(.W(64), .DEPTH(8), .NCH(4)) dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .in_valid  (in_valid),
    .in_pkt    (in_pkt),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_pkt   (out_pkt),
    .out_ch    (out_ch),
    .out_ready (out_ready),
    .occ       (occ),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] occ_of(input int c);
    return occ[c*4 +: 4];
  endfunction

  function automatic logic [15:0] drop_of(input int c);
    return drop_cnt[c*16 +: 16];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pkt(input int c, input logic [63:0] v);
    in_pkt[c*64 +: 64] = v;
  endtask

  task automatic do_reset();
    arst_n    = 1'b0;
    in_valid  = '0;
    in_pkt    = '0;
    out_ready = 1'b0;
    #12;
    arst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b exp 0", out_valid); end
    n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL reset_out_ch: got %0d exp 0", out_ch); end
    n_cmp++; if (occ !== 16'h0) begin n_err++; $display("FAIL reset_occ: got %h exp 0", occ); end
    n_cmp++; if (in_ready !== 4'hF) begin n_err++; $display("FAIL reset_in_ready: got %b exp 1111", in_ready); end
    n_cmp++; if (drop_cnt !== 64'h0) begin n_err++; $display("FAIL reset_drop_cnt: got %h exp 0", drop_cnt); end
    n_cmp++; if (out_pkt !== 64'h0) begin n_err++; $display("FAIL reset_out_pkt: got %h exp 0", out_pkt); end
  endtask

  task automatic test_single();
    do_reset();
    in_valid[2] = 1'b1; set_pkt(2, 64'hA1);
    tick();
    in_valid = '0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b exp 1", out_valid); end
    n_cmp++; if (out_ch !== 2'd2) begin n_err++; $display("FAIL single_ch: got %0d exp 2", out_ch); end
    n_cmp++; if (out_pkt !== 64'hA1) begin n_err++; $display("FAIL single_pkt: got %h exp a1", out_pkt); end
    n_cmp++; if (occ_of(2) !== 4'd1) begin n_err++; $display("FAIL single_occ: got %0d exp 1", occ_of(2)); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL single_pop_valid: got %b exp 0", out_valid); end
    n_cmp++; if (occ_of(2) !== 4'd0) begin n_err++; $display("FAIL single_pop_occ: got %0d exp 0", occ_of(2)); end
  endtask

`ifndef PKT_QUEUE_MC_DROP_EN
  task automatic test_backpressure();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid[0] = 1'b1; set_pkt(0, 64'(k));
      tick();
    end
    n_cmp++; if (in_ready[0] !== 1'b0) begin n_err++; $display("FAIL bp_full_ready: got %b exp 0", in_ready[0]); end
    n_cmp++; if (occ_of(0) !== 4'd8) begin n_err++; $display("FAIL bp_full_occ: got %0d exp 8", occ_of(0)); end
    set_pkt(0, 64'd8);
    tick();
    n_cmp++; if (occ_of(0) !== 4'd8) begin n_err++; $display("FAIL bp_held_occ: got %0d exp 8", occ_of(0)); end
    n_cmp++; if (out_pkt !== 64'd0) begin n_err++; $display("FAIL bp_head: got %h exp 0", out_pkt); end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (occ_of(0) !== 4'd7) begin n_err++; $display("FAIL bp_pop_occ: got %0d exp 7", occ_of(0)); end
    n_cmp++; if (in_ready[0] !== 1'b1) begin n_err++; $display("FAIL bp_pop_ready: got %b exp 1", in_ready[0]); end
    n_cmp++; if (out_pkt !== 64'd1) begin n_err++; $display("FAIL bp_pop_head: got %h exp 1", out_pkt); end
    tick();
    in_valid = '0;
    n_cmp++; if (occ_of(0) !== 4'd8) begin n_err++; $display("FAIL bp_refill_occ: got %0d exp 8", occ_of(0)); end
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      n_cmp++; if (out_pkt !== 64'(k)) begin n_err++; $display("FAIL bp_order: got %h exp %h", out_pkt, 64'(k)); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL bp_drained: got %b exp 0", out_valid); end
    n_cmp++; if (drop_cnt !== 64'h0) begin n_err++; $display("FAIL bp_drop_tied: got %h exp 0", drop_cnt); end
  endtask
`endif

`ifdef PKT_QUEUE_MC_DROP_EN
  task automatic test_drop();
    do_reset();
    for (int k = 0; k < 8; k++) begin
      in_valid[3] = 1'b1; set_pkt(3, 64'h30 + 64'(k));
      tick();
    end
    set_pkt(3, 64'hDD);
    repeat (3) tick();
    in_valid = '0;
    n_cmp++; if (drop_of(3) !== 16'd3) begin n_err++; $display("FAIL drop_cnt3: got %0d exp 3", drop_of(3)); end
    n_cmp++; if (occ_of(3) !== 4'd8) begin n_err++; $display("FAIL drop_occ: got %0d exp 8", occ_of(3)); end
    n_cmp++; if (in_ready !== 4'hF) begin n_err++; $display("FAIL drop_ready: got %b exp 1111", in_ready); end
    in_valid[3] = 1'b1; set_pkt(3, 64'hEE); out_ready = 1'b1;
    tick();
    in_valid = '0; out_ready = 1'b0;
    n_cmp++; if (drop_of(3) !== 16'd3) begin n_err++; $display("FAIL drop_swap_cnt: got %0d exp 3", drop_of(3)); end
    n_cmp++; if (occ_of(3) !== 4'd8) begin n_err++; $display("FAIL drop_swap_occ: got %0d exp 8", occ_of(3)); end
    n_cmp++; if (out_pkt !== 64'h31) begin n_err++; $display("FAIL drop_swap_head: got %h exp 31", out_pkt); end
    out_ready = 1'b1;
    repeat (7) tick();
    out_ready = 1'b0;
    n_cmp++; if (occ_of(3) !== 4'd1) begin n_err++; $display("FAIL drop_tail_occ: got %0d exp 1", occ_of(3)); end
    n_cmp++; if (out_pkt !== 64'hEE) begin n_err++; $display("FAIL drop_tail_pkt: got %h exp ee", out_pkt); end
  endtask
`endif

  task automatic test_round_robin();
    do_reset();
    for (int k = 0; k < 2; k++) begin
      in_valid = 4'hF;
      for (int c = 0; c < 4; c++) set_pkt(c, 64'(16 * c + k));
      tick();
    end
    in_valid = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rr_valid[%0d]: got %b exp 1", i, out_valid); end
      n_cmp++; if (out_ch !== 2'(i % 4)) begin n_err++; $display("FAIL rr_ch[%0d]: got %0d exp %0d", i, out_ch, i % 4); end
      n_cmp++; if (out_pkt !== 64'(16 * (i % 4) + i / 4)) begin n_err++; $display("FAIL rr_pkt[%0d]: got %h exp %h", i, out_pkt, 64'(16 * (i % 4) + i / 4)); end
      tick();
    end
    out_ready = 1'b0;
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rr_empty: got %b exp 0", out_valid); end
  endtask

  task automatic test_lock();
    do_reset();
    in_valid[1] = 1'b1; set_pkt(1, 64'h11);
    tick();
    in_valid = '0;
    n_cmp++; if (out_ch !== 2'd1) begin n_err++; $display("FAIL lock_first_ch: got %0d exp 1", out_ch); end
    tick();
    in_valid[0] = 1'b1; set_pkt(0, 64'h22);
    tick();
    in_valid = '0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (out_ch !== 2'd1) begin n_err++; $display("FAIL lock_hold_ch[%0d]: got %0d exp 1", i, out_ch); end
      n_cmp++; if (out_pkt !== 64'h11) begin n_err++; $display("FAIL lock_hold_pkt[%0d]: got %h exp 11", i, out_pkt); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_cmp++; if (out_ch !== 2'd0) begin n_err++; $display("FAIL lock_next_ch: got %0d exp 0", out_ch); end
    n_cmp++; if (out_pkt !== 64'h22) begin n_err++; $display("FAIL lock_next_pkt: got %h exp 22", out_pkt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      in_valid[0] = 1'b1; set_pkt(0, 64'h40 + 64'(k));
      tick();
    end
    in_valid = '0;
    n_cmp++; if (occ_of(0) !== 4'd5) begin n_err++; $display("FAIL mid_occ_pre: got %0d exp 5", occ_of(0)); end
    #2 arst_n = 1'b0;
    #1;
    n_cmp++; if (occ !== 16'h0) begin n_err++; $display("FAIL mid_occ_async: got %h exp 0", occ); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid_async: got %b exp 0", out_valid); end
    #4 arst_n = 1'b1;
    tick();
    in_valid[3] = 1'b1; set_pkt(3, 64'h5A);
    tick();
    in_valid = '0;
    n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_post_valid: got %b exp 1", out_valid); end
    n_cmp++; if (out_ch !== 2'd3) begin n_err++; $display("FAIL mid_post_ch: got %0d exp 3", out_ch); end
    n_cmp++; if (out_pkt !== 64'h5A) begin n_err++; $display("FAIL mid_post_pkt: got %h exp 5a", out_pkt); end
    n_cmp++; if (occ_of(3) !== 4'd1) begin n_err++; $display("FAIL mid_post_occ: got %0d exp 1", occ_of(3)); end
  endtask

  initial begin
    test_reset();
    test_single();
`ifndef PKT_QUEUE_MC_DROP_EN
    test_backpressure();
`else
    test_drop();
`endif
    test_round_robin();
    test_lock();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
